hsm_cmd_sequencer: RTL and testbench
====================================

# hsm_cmd_sequencer

Single-requester command engine that drives the HSM's 32-bit AXI4-Lite register slave as a bus master. Local logic (self-test, key loader, control FSMs) issues one command at a time: register write, register read, or poll-until-match with a bounded retry count. The engine sequences the AXI-Lite channels, checks responses, and returns one status-tagged result per command. It sits between the control logic and the HSM bridge slave port, in the same clock/reset domain.

## Interface
- C_M_AXI_ADDR_WIDTH, 5, byte address width of the HSM register space
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- POLL_CNT_W, 16, width of the poll retry limit
- S_AXI_ACLK  in  1  single clock; all logic rising-edge
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- req_valid / req_ready  in / out  1 / 1  command handshake
- req_op  in  2  00 write, 01 read, 10 poll, 11 illegal
- req_addr  in  C_M_AXI_ADDR_WIDTH  register byte address
- req_data  in  32  write data (write) or expected value (poll)
- req_mask  in  32  poll compare mask
- req_limit  in  POLL_CNT_W  extra poll reads allowed after the first
- rsp_valid / rsp_ready  out / in  1 / 1  result handshake
- rsp_data  out  32  read data (read/poll), 0 otherwise
- rsp_status  out  2  00 OK, 01 bus error, 10 poll timeout, 11 illegal op
- M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: req_ready=1. On req_valid: latch op/addr/data/mask/limit, clear poll counter. Write goes to WR_ADDR_DATA, read/poll to RD_ADDR, illegal to RESP with status 11 and data 0.
- WR_ADDR_DATA: AWVALID and WVALID raised together; each drops independently on its own handshake (aw_done/w_done flags). Exit to WR_RESP when both are done, including same-cycle completion.
- WR_RESP: BREADY=1. On BVALID, status = (BRESP==00) ? 00 : 01, then RESP.
- RD_ADDR: ARVALID=1 until ARREADY, then RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA.
  - Nonzero RRESP: status 01, then RESP.
  - Read: status 00, then RESP.
  - Poll: if (RDATA & mask) == (data & mask), status 00, then RESP. Else if counter == limit, status 10, then RESP. Else increment counter and return to RD_ADDR.
- RESP: rsp_valid held with stable data and status until rsp_ready, then IDLE.
- Constants: AWPROT=ARPROT=000, WSTRB=1111. AWADDR/ARADDR/WDATA come from latched registers and stay stable while valid.
- Poll with limit=0 does exactly one read. Limit 2^POLL_CNT_W-1 does 2^POLL_CNT_W reads. The counter never wraps.

## Timing
- Reset values: req_ready=1 (state decode), rsp_valid=0, rsp_data=0, rsp_status=00, all AXI VALID/READY outputs=0, addresses and WDATA=0.
- Every AXI output is registered.
- AW/W/AR valid rises the cycle after the req handshake.
- rsp_valid rises the cycle after the terminating B or R handshake.
- Zero-wait slave latency, request acceptance to rsp_valid: write 3 cycles, read 3 cycles, each extra poll read +2.
- The next req is accepted no earlier than the cycle after the rsp handshake.
- Reset asserted mid-operation: all valids drop immediately and the transaction is abandoned. The HSM slave shares S_AXI_ARESETN.
- Inputs on req_* are ignored outside IDLE.

## Structure
- Package hsm_seq_pkg:
  - op_e: WRITE, READ, POLL, ILLEGAL
  - status_e: OK, BUSERR, TIMEOUT, ILLEGAL
  - state_e
  - AXI_RESP_OKAY=2'b00, AXI_PROT_DEF=3'b000
- Single module with no sub-module; the response stage is a registered holding slot inside the FSM.

## Test plan
- Write addr 0x08 data 0xDEADBEEF, slave ready immediately -> one AW+W handshake with those values, rsp status 00, data 0, rsp_valid 3 cycles after accept.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 4 cycles, exactly one B handshake, status 00.
- Read addr 0x10, slave returns 0x12345678 RRESP=10 -> status 01, data 0x12345678.
- Poll addr 0x04, mask 0x1, expect 0x1, limit 5, slave returns 0,0,1 -> exactly 3 AR handshakes, status 00, data 0x1.
- Poll, limit 2, bit never set -> exactly 3 reads, status 10; req_op=11 -> no bus activity, status 11 next cycle.
- Reset asserted during RD_DATA with rsp_ready held low -> all outputs at reset values same cycle, req_ready=1 after release.

Source files
------------

// File: rtl/hsm_cmd_sequencer_pkg.sv
// Shared types and constants for the HSM command sequencer: opcodes, result
// status codes, FSM states and fixed AXI-Lite field values.
package hsm_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_POLL    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_BUSERR  = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ILLEGAL = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] AXI_PROT_DEF  = 3'b000;

    function automatic logic poll_match(input logic [31:0] rdata,
                                        input logic [31:0] expected,
                                        input logic [31:0] mask);
        return ((rdata ^ expected) & mask) == '0;
    endfunction

endpackage

// File: rtl/hsm_cmd_sequencer_if.sv
// Command/response handshake plus AXI4-Lite master channels of the sequencer.
// master = the sequencer itself, slave = control logic and HSM register port.
interface hsm_cmd_sequencer_if #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned POLL_CNT_W = 16
);
    import hsm_seq_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_data;
    logic [DATA_W-1:0]     req_mask;
    logic [POLL_CNT_W-1:0] req_limit;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic [1:0]            rsp_status;

    logic [ADDR_W-1:0]     M_AXI_AWADDR;
    logic [2:0]            M_AXI_AWPROT;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_W-1:0]     M_AXI_WDATA;
    logic [DATA_W/8-1:0]   M_AXI_WSTRB;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;
    logic [ADDR_W-1:0]     M_AXI_ARADDR;
    logic [2:0]            M_AXI_ARPROT;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_W-1:0]     M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        input  req_valid, req_op, req_addr, req_data, req_mask, req_limit,
        output req_ready,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output req_valid, req_op, req_addr, req_data, req_mask, req_limit,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/hsm_cmd_sequencer.sv
// Single-requester command engine: turns write/read/poll commands into
// AXI4-Lite master transactions and returns one status-tagged result each.
module hsm_cmd_sequencer
    import hsm_seq_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned POLL_CNT_W         = 16
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    hsm_cmd_sequencer_if.master bus
);

    state_e                          state_q;
    op_e                             op_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   mask_q;
    logic [POLL_CNT_W-1:0]           limit_q;
    logic [POLL_CNT_W-1:0]           cnt_q;
    logic                            awvalid_q, wvalid_q, aw_done_q, w_done_q;
    logic                            bready_q, arvalid_q, rready_q;
    logic                            rsp_valid_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data_q;
    status_e                         rsp_status_q;

    logic aw_hs, w_hs, aw_fin, w_fin;

    assign aw_hs  = awvalid_q & bus.M_AXI_AWREADY;
    assign w_hs   = wvalid_q  & bus.M_AXI_WREADY;
    // Handshakes of this cycle count as done so same-cycle completion exits at once.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q  | w_hs;

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWPROT  = AXI_PROT_DEF;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_WDATA   = data_q;
    assign bus.M_AXI_WSTRB   = '1;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_BREADY  = bready_q;
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARPROT  = AXI_PROT_DEF;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_RREADY  = rready_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= S_IDLE;
            op_q         <= OP_WRITE;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            limit_q      <= '0;
            cnt_q        <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= op_e'(bus.req_op);
                        addr_q  <= bus.req_addr;
                        data_q  <= bus.req_data;
                        mask_q  <= bus.req_mask;
                        limit_q <= bus.req_limit;
                        cnt_q   <= '0;
                        case (op_e'(bus.req_op))
                            OP_WRITE: begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                aw_done_q <= 1'b0;
                                w_done_q  <= 1'b0;
                                state_q   <= S_WR_ADDR_DATA;
                            end
                            OP_READ, OP_POLL: begin
                                arvalid_q <= 1'b1;
                                state_q   <= S_RD_ADDR;
                            end
                            default: begin
                                rsp_valid_q  <= 1'b1;
                                rsp_data_q   <= '0;
                                rsp_status_q <= ST_ILLEGAL;
                                state_q      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bus.M_AXI_BVALID) begin
                        bready_q     <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_status_q <= (bus.M_AXI_BRESP == AXI_RESP_OKAY) ? ST_OK : ST_BUSERR;
                        state_q      <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (bus.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (bus.M_AXI_RVALID) begin
                        rready_q   <= 1'b0;
                        rsp_data_q <= bus.M_AXI_RDATA;
                        if (bus.M_AXI_RRESP != AXI_RESP_OKAY) begin
                            rsp_status_q <= ST_BUSERR;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (op_q == OP_READ ||
                                     poll_match(bus.M_AXI_RDATA, data_q, mask_q)) begin
                            rsp_status_q <= ST_OK;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (cnt_q == limit_q) begin
                            rsp_status_q <= ST_TIMEOUT;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            // Retry: limit_q bounds cnt_q, so it can never wrap.
                            cnt_q     <= cnt_q + 1'b1;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsm_cmd_sequencer.sv
// Randomized bench for hsm_cmd_sequencer: reactive AXI-Lite slave with
// configurable delays, plus a per-command reference model of the result.
module tb_hsm_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hsm_cmd_sequencer_if #(.ADDR_W(5), .DATA_W(32), .POLL_CNT_W(16)) bus ();

    hsm_cmd_sequencer #(
        .C_M_AXI_ADDR_WIDTH(5),
        .C_M_AXI_DATA_WIDTH(32),
        .POLL_CNT_W(16)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // command under test
    logic [1:0]  c_op;
    logic [4:0]  c_addr;
    logic [31:0] c_data, c_mask;
    int unsigned c_limit;

    // slave behaviour
    int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  bresp_cfg;
    logic [31:0] rd_q[$];
    logic [1:0]  rr_q[$];

    // model expectations
    logic [31:0] e_data;
    logic [1:0]  e_status;
    int          e_reads, e_writes, e_lat;

    // observations
    int          cyc = 0;
    int          acc_cyc, n_aw, n_w, n_b, n_ar, n_r, aw_hi, w_hi, last_lat;
    bit          busy, acc_flag, done_flag, prev_rsp;
    bit          s_aw, s_w, s_b, s_ar, s_r;
    logic [31:0] last_data;
    logic [1:0]  last_status;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Result computed from the command rules and the queued slave read data.
    task automatic compute_expect();
        bit fin;
        bit zero;
        e_data = '0; e_status = 2'b00; e_reads = 0; e_writes = 0;
        case (c_op)
            2'b00: begin
                e_writes = 1;
                e_status = (bresp_cfg == 2'b00) ? 2'b00 : 2'b01;
            end
            2'b01, 2'b10: begin
                fin = 1'b0;
                for (int i = 0; i < rd_q.size() && !fin; i++) begin
                    e_reads = i + 1;
                    e_data  = rd_q[i];
                    fin = 1'b1;
                    if (rr_q[i] != 2'b00)                                e_status = 2'b01;
                    else if (c_op == 2'b01)                             e_status = 2'b00;
                    else if ((rd_q[i] & c_mask) == (c_data & c_mask))   e_status = 2'b00;
                    else if (i == int'(c_limit))                        e_status = 2'b10;
                    else fin = 1'b0;
                end
            end
            default: e_status = 2'b11;
        endcase
        zero = (c_op == 2'b00) ? (aw_dly == 0 && w_dly == 0 && b_dly == 0)
                               : (ar_dly == 0 && r_dly == 0);
        if (c_op == 2'b11)  e_lat = 1;
        else if (!zero)     e_lat = -1;
        else if (c_op == 2'b00) e_lat = 3;
        else                e_lat = 3 + 2 * (e_reads - 1);
    endtask

    // Monitor / compare process: samples mid-cycle, at the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            busy = 1'b0; prev_rsp = 1'b0;
            s_aw = 1'b0; s_w = 1'b0; s_b = 1'b0; s_ar = 1'b0; s_r = 1'b0;
        end else begin
            s_aw = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
            s_w  = bus.M_AXI_WVALID  && bus.M_AXI_WREADY;
            s_b  = bus.M_AXI_BVALID  && bus.M_AXI_BREADY;
            s_ar = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            s_r  = bus.M_AXI_RVALID  && bus.M_AXI_RREADY;
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            if (!busy) begin
                chk("idle_quiet", {26'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                   bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.rsp_valid}, 32'd0);
            end else begin
                if (bus.M_AXI_AWVALID) aw_hi++;
                if (bus.M_AXI_WVALID)  w_hi++;
                if (s_aw) begin
                    n_aw++;
                    chk("awaddr", 32'(bus.M_AXI_AWADDR), 32'(c_addr));
                    chk("awprot", 32'(bus.M_AXI_AWPROT), 32'd0);
                end
                if (s_w) begin
                    n_w++;
                    chk("wdata", bus.M_AXI_WDATA, c_data);
                    chk("wstrb", 32'(bus.M_AXI_WSTRB), 32'hF);
                end
                if (s_b) n_b++;
                if (s_ar) begin
                    n_ar++;
                    chk("araddr", 32'(bus.M_AXI_ARADDR), 32'(c_addr));
                    chk("arprot", 32'(bus.M_AXI_ARPROT), 32'd0);
                end
                if (s_r) n_r++;
                if (bus.rsp_valid) begin
                    chk("rsp_data", bus.rsp_data, e_data);
                    chk("rsp_status", 32'(bus.rsp_status), 32'(e_status));
                    if (!prev_rsp) begin
                        last_lat = cyc - acc_cyc;
                        if (e_lat >= 0) chk("latency", 32'(last_lat), 32'(e_lat));
                    end
                    if (bus.rsp_ready) begin
                        chk("n_ar", 32'(n_ar), 32'(e_reads));
                        chk("n_r",  32'(n_r),  32'(e_reads));
                        chk("n_aw", 32'(n_aw), 32'(e_writes));
                        chk("n_w",  32'(n_w),  32'(e_writes));
                        chk("n_b",  32'(n_b),  32'(e_writes));
                        last_data   = bus.rsp_data;
                        last_status = bus.rsp_status;
                        busy = 1'b0;
                        done_flag = 1'b1;
                    end
                end
            end
            prev_rsp = bus.rsp_valid;
            if (bus.req_valid && bus.req_ready) begin
                busy = 1'b1; acc_flag = 1'b1; acc_cyc = cyc;
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_hi = 0; w_hi = 0;
            end
        end
    end

    // Reactive AXI-Lite slave, updated just after each rising edge.
    initial begin
        int unsigned aw_c, w_c, b_c, ar_c, r_c;
        bit got_aw, got_w, r_pend;
        bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0;
        bus.M_AXI_BRESP = 2'b00; bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = 2'b00;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        got_aw = 1'b0; got_w = 1'b0; r_pend = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0;
                bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                got_aw = 1'b0; got_w = 1'b0; r_pend = 1'b0;
                continue;
            end
            if (s_aw) begin bus.M_AXI_AWREADY = 1'b0; got_aw = 1'b1; aw_c = 0; end
            if (s_w)  begin bus.M_AXI_WREADY  = 1'b0; got_w  = 1'b1; w_c  = 0; end
            if (s_b)  begin bus.M_AXI_BVALID  = 1'b0; got_aw = 1'b0; got_w = 1'b0; end
            if (s_ar) begin bus.M_AXI_ARREADY = 1'b0; r_pend = 1'b1; r_c = 0; end
            if (s_r)  bus.M_AXI_RVALID = 1'b0;
            if (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) begin
                if (aw_c >= aw_dly) bus.M_AXI_AWREADY = 1'b1; else aw_c++;
            end
            if (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) begin
                if (w_c >= w_dly) bus.M_AXI_WREADY = 1'b1; else w_c++;
            end
            if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) begin
                if (ar_c >= ar_dly) bus.M_AXI_ARREADY = 1'b1; else ar_c++;
            end
            if (got_aw && got_w && !bus.M_AXI_BVALID) begin
                if (b_c >= b_dly) begin
                    bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = bresp_cfg; b_c = 0;
                end else b_c++;
            end
            if (r_pend && !bus.M_AXI_RVALID) begin
                if (r_c >= r_dly) begin
                    bus.M_AXI_RVALID = 1'b1;
                    if (rd_q.size() > 0) begin
                        bus.M_AXI_RDATA = rd_q.pop_front();
                        bus.M_AXI_RRESP = rr_q.pop_front();
                    end else begin
                        bus.M_AXI_RDATA = $urandom;
                        bus.M_AXI_RRESP = 2'b00;
                    end
                    r_pend = 1'b0; r_c = 0;
                end else r_c++;
            end
        end
    end

    task automatic set_dly(input int unsigned aw, input int unsigned w, input int unsigned b,
                           input int unsigned ar, input int unsigned r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                           input logic [31:0] mask, input int unsigned limit);
        c_op = op; c_addr = addr; c_data = data; c_mask = mask; c_limit = limit;
        compute_expect();
    endtask

    task automatic send_req();
        int t;
        @(posedge clk); #2;
        acc_flag = 1'b0; done_flag = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = c_op; bus.req_addr = c_addr;
        bus.req_data = c_data; bus.req_mask = c_mask; bus.req_limit = 16'(c_limit);
        bus.rsp_ready = 1'b0;
        t = 0;
        while (!acc_flag && t < 50) begin @(negedge clk); #1; t++; end
        chk("accept", 32'(acc_flag), 32'd1);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
    endtask

    // Issue, then wiggle rsp_ready and drive ignored junk on req_* while busy.
    task automatic run_cmd();
        int t;
        send_req();
        t = 0;
        while (!done_flag && t < 400) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (bus.rsp_ready) bus.req_valid = 1'b0;
            else begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_op    = 2'($urandom);
                bus.req_addr  = 5'($urandom);
                bus.req_data  = $urandom;
                bus.req_limit = 16'($urandom);
            end
            @(posedge clk); #2;
            t++;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("rsp_done", 32'(done_flag), 32'd1);
        rd_q.delete(); rr_q.delete();
    endtask

    initial begin
        int t;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_data = '0;
        bus.req_mask = '0; bus.req_limit = '0; bus.rsp_ready = 1'b0;
        bresp_cfg = 2'b00;
        set_dly(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp", {bus.rsp_data[29:0], bus.rsp_status} , 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_axi", {26'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                        bus.M_AXI_BREADY, bus.M_AXI_RREADY, 1'b0}, 32'd0);
        chk("rst_addr_wdata", bus.M_AXI_WDATA | 32'(bus.M_AXI_AWADDR) | 32'(bus.M_AXI_ARADDR), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // write, zero-wait slave
        set_cmd(2'b00, 5'h08, 32'hDEADBEEF, 32'h0, 0);
        run_cmd();
        chk("t1_status", 32'(last_status), 32'd0);
        chk("t1_data", last_data, 32'd0);
        chk("t1_lat", 32'(last_lat), 32'd3);

        // AWREADY held off 3 cycles, WREADY immediate
        set_dly(3, 0, 0, 0, 0);
        set_cmd(2'b00, 5'h0C, 32'h0BADF00D, 32'h0, 0);
        run_cmd();
        chk("t2_aw_hi", 32'(aw_hi), 32'd4);
        chk("t2_w_hi", 32'(w_hi), 32'd1);
        chk("t2_nb", 32'(n_b), 32'd1);
        chk("t2_status", 32'(last_status), 32'd0);

        // read with SLVERR
        set_dly(0, 0, 0, 0, 0);
        rd_q.push_back(32'h12345678); rr_q.push_back(2'b10);
        set_cmd(2'b01, 5'h10, 32'h0, 32'h0, 0);
        run_cmd();
        chk("t3_status", 32'(last_status), 32'd1);
        chk("t3_data", last_data, 32'h12345678);

        // poll matching on the third read
        rd_q = '{32'h0, 32'h0, 32'h1}; rr_q = '{2'b00, 2'b00, 2'b00};
        set_cmd(2'b10, 5'h04, 32'h1, 32'h1, 5);
        run_cmd();
        chk("t4_nar", 32'(n_ar), 32'd3);
        chk("t4_status", 32'(last_status), 32'd0);
        chk("t4_data", last_data, 32'h1);
        chk("t4_lat", 32'(last_lat), 32'd7);

        // poll timeout, limit 2
        rd_q = '{32'hFFFFFFFE, 32'h0, 32'h2}; rr_q = '{2'b00, 2'b00, 2'b00};
        set_cmd(2'b10, 5'h04, 32'h1, 32'h1, 2);
        run_cmd();
        chk("t5_nar", 32'(n_ar), 32'd3);
        chk("t5_status", 32'(last_status), 32'd2);
        chk("t5_data", last_data, 32'h2);

        // illegal opcode
        set_cmd(2'b11, 5'h1C, 32'h5555AAAA, 32'h0, 0);
        run_cmd();
        chk("t6_bus", 32'(n_aw + n_w + n_ar), 32'd0);
        chk("t6_status", 32'(last_status), 32'd3);
        chk("t6_lat", 32'(last_lat), 32'd1);

        // poll, limit 0: exactly one read
        rd_q = '{32'h0}; rr_q = '{2'b00};
        set_cmd(2'b10, 5'h14, 32'h80, 32'h80, 0);
        run_cmd();
        chk("t7_nar", 32'(n_ar), 32'd1);
        chk("t7_status", 32'(last_status), 32'd2);

        // reset while waiting in the read-data phase
        set_dly(0, 0, 0, 0, 30);
        rd_q = '{32'hA5A5A5A5}; rr_q = '{2'b00};
        set_cmd(2'b01, 5'h0C, 32'h0, 32'h0, 0);
        send_req();
        t = 0;
        while (n_ar == 0 && t < 20) begin @(negedge clk); #1; t++; end
        chk("t8_ar_seen", 32'(n_ar), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        chk("t8_rready_before", 32'(bus.M_AXI_RREADY), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_valids", {26'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                          bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.rsp_valid}, 32'd0);
        chk("t8_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t8_rsp", bus.rsp_data | 32'(bus.rsp_status), 32'd0);
        chk("t8_addr", 32'(bus.M_AXI_ARADDR), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_q.delete(); rr_q.delete();
        @(negedge clk); #1;
        chk("t8_req_ready_after", 32'(bus.req_ready), 32'd1);

        // randomized commands
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  op;
            logic [31:0] d, m;
            int unsigned lim;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) set_dly(0, 0, 0, 0, 0);
            else set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            bresp_cfg = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            d   = $urandom;
            m   = $urandom & 32'h0000_00FF;
            lim = $urandom_range(0, 4);
            if (op == 2'b01) begin
                rd_q.push_back($urandom);
                rr_q.push_back(($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end else if (op == 2'b10) begin
                for (int k = 0; k <= int'(lim); k++) begin
                    if ($urandom_range(0, 3) == 0) rd_q.push_back((d & m) | ($urandom & ~m));
                    else rd_q.push_back($urandom);
                    rr_q.push_back(($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
                end
            end
            set_cmd(op, 5'($urandom), d, m, lim);
            run_cmd();
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
